// File: rtl/cfg_lut_array_pkg.sv
// Shared sizing helpers, field offsets and FSM state type for the
// runtime-programmable LUT array.
package cfg_lut_array_pkg;

  localparam int unsigned DEF_NUM_LUTS = 16;
  localparam int unsigned DEF_LUT_K    = 4;
  localparam int unsigned DEF_NUM_IN   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } cfg_state_e;

  function automatic int unsigned sel_width(input int unsigned num_in);
    return (num_in > 32'd1) ? $clog2(num_in) : 32'd1;
  endfunction

  function automatic int unsigned tt_width(input int unsigned k);
    return 32'd1 << k;
  endfunction

  // Offset of select field j inside one LUT config word
  function automatic int unsigned sel_offset(input int unsigned k, input int unsigned sel_w,
                                             input int unsigned j);
    return tt_width(k) + j * sel_w;
  endfunction

  function automatic int unsigned reg_en_offset(input int unsigned k, input int unsigned sel_w);
    return tt_width(k) + k * sel_w;
  endfunction

  function automatic int unsigned lut_cfg_width(input int unsigned k, input int unsigned sel_w);
    return reg_en_offset(k, sel_w) + 32'd1;
  endfunction

  function automatic int unsigned total_width(input int unsigned num_luts,
                                              input int unsigned cfg_w);
    return num_luts * cfg_w;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned total_w);
    return $clog2(total_w + 32'd1);
  endfunction

  localparam int unsigned LUT_CFG_W = lut_cfg_width(DEF_LUT_K, sel_width(DEF_NUM_IN));
  localparam int unsigned TOTAL_W   = total_width(DEF_NUM_LUTS, LUT_CFG_W);
  localparam int unsigned CNT_W     = cnt_width(TOTAL_W);

endpackage

// File: rtl/cfg_lut_array_cell.sv
// One K-input LUT: routing muxes, truth-table lookup and optional output flop.
module cfg_lut_cell
  import cfg_lut_array_pkg::*;
#(
  parameter int unsigned LUT_K  = 4,
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned SEL_W  = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_IN-1:0]                      fpga_in,
  input  logic [lut_cfg_width(LUT_K, SEL_W)-1:0] cfg,
  output logic                                   lut_out_c
);

  localparam int unsigned TT_W   = tt_width(LUT_K);
  localparam int unsigned REG_OF = reg_en_offset(LUT_K, SEL_W);

  logic [TT_W-1:0]  tt;
  logic [SEL_W-1:0] sel;
  logic [LUT_K-1:0] idx;
  logic             lut_val;
  logic             lut_q;
  logic             reg_en;

  assign tt     = cfg[TT_W-1:0];
  assign reg_en = cfg[REG_OF];

  // Out-of-range selects tie the LUT input low
  always_comb begin
    idx     = '0;
    sel     = '0;
    for (int unsigned j = 0; j < LUT_K; j++) begin
      sel = cfg[sel_offset(LUT_K, SEL_W, j) +: SEL_W];
      if (32'(sel) < NUM_IN) idx[j] = fpga_in[sel];
    end
    lut_val = tt[idx];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) lut_q <= 1'b0;
    else        lut_q <= lut_val;
  end

  assign lut_out_c = reg_en ? lut_q : lut_val;

endmodule

// File: rtl/cfg_lut_array.sv
// Runtime-programmable LUT array: serial config load into a shadow register,
// atomic commit to the active config that drives the LUT cells.
module cfg_lut_array
  import cfg_lut_array_pkg::*;
#(
  parameter int unsigned NUM_LUTS = DEF_NUM_LUTS,
  parameter int unsigned LUT_K    = DEF_LUT_K,
  parameter int unsigned NUM_IN   = DEF_NUM_IN
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_IN-1:0]   fpga_in,
  output logic [NUM_LUTS-1:0] fpga_out,
  input  logic                cfg_start,
  input  logic                cfg_abort,
  input  logic                cfg_valid,
  input  logic                cfg_din,
  output logic                cfg_ready,
  output logic                cfg_done,
  output logic                cfg_busy
);

  localparam int unsigned SEL_W  = sel_width(NUM_IN);
  localparam int unsigned CELL_W = lut_cfg_width(LUT_K, SEL_W);
  localparam int unsigned STRM_W = total_width(NUM_LUTS, CELL_W);
  localparam int unsigned COUNT_W = cnt_width(STRM_W);

  cfg_state_e         state_q, state_d;
  logic [COUNT_W-1:0] cnt_q;
  logic [STRM_W-1:0]  shadow_q;
  logic [STRM_W-1:0]  active_q;
  logic               ready_q, busy_q, done_q;
  logic               accept_c, last_c, shift_en, cnt_clr, commit_en;

  // Next-state and datapath enables; abort outranks a coincident final bit
  always_comb begin
    state_d   = state_q;
    shift_en  = 1'b0;
    cnt_clr   = 1'b0;
    commit_en = 1'b0;
    accept_c  = cfg_valid && (state_q == LOAD);
    last_c    = (cnt_q == COUNT_W'(STRM_W - 1));
    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          state_d = LOAD;
          cnt_clr = 1'b1;
        end
      end
      LOAD: begin
        if (cfg_abort) begin
          state_d = IDLE;
        end else if (accept_c) begin
          shift_en = 1'b1;
          if (last_c) state_d = COMMIT;
        end
      end
      COMMIT: begin
        commit_en = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == LOAD);
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == COMMIT);
    end
  end

  // Shadow shifts right with new bits entering at the MSB
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      if (cnt_clr)       cnt_q <= '0;
      else if (shift_en) cnt_q <= cnt_q + COUNT_W'(1);
      if (shift_en)  shadow_q <= {cfg_din, shadow_q[STRM_W-1:1]};
      if (commit_en) active_q <= shadow_q;
    end
  end

  assign cfg_ready = ready_q;
  assign cfg_busy  = busy_q;
  assign cfg_done  = done_q;

  for (genvar i = 0; i < NUM_LUTS; i++) begin : g_cell
    cfg_lut_cell #(
      .LUT_K (LUT_K),
      .NUM_IN(NUM_IN),
      .SEL_W (SEL_W)
    ) u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .fpga_in  (fpga_in),
      .cfg      (active_q[i*CELL_W +: CELL_W]),
      .lut_out_c(fpga_out[i])
    );
  end

endmodule

// File: tb/tb_cfg_lut_array.sv
// Randomized self-checking bench for cfg_lut_array against a behavioural model.
module tb_cfg_lut_array;

  localparam int NL = 16;
  localparam int NI = 4;
  localparam int CW = 25;
  localparam int TW = NL * CW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NI-1:0] fpga_in;
  logic [NL-1:0] fpga_out;
  logic          cfg_start, cfg_abort, cfg_valid, cfg_din;
  logic          cfg_ready, cfg_done, cfg_busy;

  int checks = 0;
  int fails  = 0;
  int done_cnt = 0;
  int ready_cyc = 0;

  // Desired config to load and its serial stream
  logic [15:0] d_tt  [NL];
  int          d_sel [NL][4];
  bit          d_reg [NL];
  bit          tx    [TW];

  // Behavioural model state
  bit          m_live = 1'b0;
  bit          m_loading, m_commit;
  int          m_cnt;
  bit          m_stream [TW];
  logic [15:0] a_tt  [NL];
  int          a_sel [NL][4];
  bit          a_reg [NL];
  bit          m_regq [NL];

  cfg_lut_array #(.NUM_LUTS(NL), .LUT_K(4), .NUM_IN(NI)) dut (
    .clk(clk), .rst_n(rst_n), .fpga_in(fpga_in), .fpga_out(fpga_out),
    .cfg_start(cfg_start), .cfg_abort(cfg_abort), .cfg_valid(cfg_valid),
    .cfg_din(cfg_din), .cfg_ready(cfg_ready), .cfg_done(cfg_done), .cfg_busy(cfg_busy)
  );

  always #5 clk = ~clk;

  function automatic bit lut_eval(input int i, input logic [3:0] in);
    int idx = 0;
    for (int j = 0; j < 4; j++)
      if (a_sel[i][j] < NI && in[a_sel[i][j]] == 1'b1) idx = idx + (1 << j);
    return a_tt[i][idx];
  endfunction

  function automatic void encode();
    for (int i = 0; i < NL; i++)
      for (int b = 0; b < CW; b++) begin
        if (b < 16)      tx[i*CW + b] = d_tt[i][b];
        else if (b < 24) tx[i*CW + b] = ((d_sel[i][(b-16)/2] >> ((b-16)%2)) & 1) != 0;
        else             tx[i*CW + b] = d_reg[i];
      end
  endfunction

  function automatic void clear_desired();
    for (int i = 0; i < NL; i++) begin
      d_tt[i] = 16'h0; d_reg[i] = 1'b0;
      for (int j = 0; j < 4; j++) d_sel[i][j] = 0;
    end
  endfunction

  function automatic void random_desired();
    for (int i = 0; i < NL; i++) begin
      d_tt[i] = 16'($urandom); d_reg[i] = 1'($urandom);
      for (int j = 0; j < 4; j++) d_sel[i][j] = int'($urandom_range(0, 3));
    end
  endfunction

  // Model advances on each rising edge from the inputs held across it
  always @(posedge clk) begin
    if (!rst_n) begin
      m_live = 1'b1; m_loading = 1'b0; m_commit = 1'b0; m_cnt = 0;
      for (int i = 0; i < NL; i++) begin
        a_tt[i] = 16'h0; a_reg[i] = 1'b0; m_regq[i] = 1'b0;
        for (int j = 0; j < 4; j++) a_sel[i][j] = 0;
      end
    end else if (m_live) begin
      for (int i = 0; i < NL; i++) m_regq[i] = lut_eval(i, fpga_in);
      if (m_commit) begin
        m_commit = 1'b0;
        for (int i = 0; i < NL; i++) begin
          for (int n = 0; n < 16; n++) a_tt[i][n] = m_stream[i*CW + n];
          for (int j = 0; j < 4; j++)
            a_sel[i][j] = int'(m_stream[i*CW + 16 + 2*j]) + 2 * int'(m_stream[i*CW + 17 + 2*j]);
          a_reg[i] = m_stream[i*CW + 24];
        end
      end else if (m_loading) begin
        if (cfg_abort) m_loading = 1'b0;
        else if (cfg_valid) begin
          m_stream[m_cnt] = cfg_din;
          m_cnt++;
          if (m_cnt == TW) begin m_loading = 1'b0; m_commit = 1'b1; end
        end
      end else if (cfg_start) begin
        m_loading = 1'b1; m_cnt = 0;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    logic [NL-1:0] exp_out;
    logic [2:0]    exp_ctl;
    if (m_live) begin
      for (int i = 0; i < NL; i++) exp_out[i] = a_reg[i] ? m_regq[i] : lut_eval(i, fpga_in);
      exp_ctl = {m_loading, m_loading | m_commit, m_commit};
      checks++;
      if (fpga_out !== exp_out) begin
        fails++;
        $display("FAIL model_out t=%0t got=%h exp=%h", $time, fpga_out, exp_out);
      end
      checks++;
      if ({cfg_ready, cfg_busy, cfg_done} !== exp_ctl) begin
        fails++;
        $display("FAIL model_ctl t=%0t got(rdy,busy,done)=%b exp=%b", $time,
                 {cfg_ready, cfg_busy, cfg_done}, exp_ctl);
      end
    end
  end

  always @(negedge clk) begin
    if (cfg_done === 1'b1)  done_cnt++;
    if (cfg_ready === 1'b1) ready_cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  // mode 0: back-to-back bits, 1: valid every other cycle, 2: random gaps
  task automatic load(input int mode, input int abort_at, input int rst_at);
    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    for (int b = 0; b < TW; b++) begin
      if (b == rst_at) begin
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        return;
      end
      cfg_valid = 1'b1; cfg_din = tx[b]; cfg_abort = (b == abort_at);
      cfg_start = ($urandom_range(0, 7) == 0) && (b != abort_at);
      fpga_in = 4'($urandom);
      tick();
      cfg_valid = 1'b0; cfg_abort = 1'b0; cfg_start = 1'b0;
      if (b == abort_at) return;
      if (b == TW - 1) begin
        @(negedge clk); chk("done_after_last", 32'(cfg_done), 32'd1);
        tick();
      end else if (mode == 1) begin
        tick();
      end else if (mode == 2) begin
        repeat ($urandom_range(0, 2)) begin fpga_in = 4'($urandom); tick(); end
      end
    end
  endtask

  initial begin
    int d0, r0;
    rst_n = 1'b0; fpga_in = 4'hF;
    cfg_start = 1'b0; cfg_abort = 1'b0; cfg_valid = 1'b0; cfg_din = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_out", 32'(fpga_out), 32'h0);
    chk("reset_ready", 32'(cfg_ready), 32'd0);
    chk("reset_busy", 32'(cfg_busy), 32'd0);
    rst_n = 1'b1; tick();

    // LUT0 = AND4, combinational
    clear_desired();
    d_tt[0] = 16'h8000;
    for (int j = 0; j < 4; j++) d_sel[0][j] = j;
    encode();
    d0 = done_cnt;
    load(0, -1, -1);
    chk("and_done_once", 32'(done_cnt - d0), 32'd1);
    fpga_in = 4'hF; @(negedge clk); chk("and_in_f", 32'(fpga_out), 32'h0001);
    tick(); fpga_in = 4'hE; @(negedge clk); chk("and_in_e", 32'(fpga_out), 32'h0000);
    tick();

    // LUT1 = XOR4, registered
    d_tt[1] = 16'h6996; d_reg[1] = 1'b1;
    for (int j = 0; j < 4; j++) d_sel[1][j] = 3 - j;
    encode();
    load(2, -1, -1);
    fpga_in = 4'h1; tick(); @(negedge clk); chk("xor_in1", 32'(fpga_out[1]), 32'd1);
    tick(); fpga_in = 4'h3; @(negedge clk); chk("xor_in3_hold", 32'(fpga_out[1]), 32'd1);
    tick(); @(negedge clk); chk("xor_in3", 32'(fpga_out[1]), 32'd0);
    tick();

    // Aborts mid-stream and coincident with the final bit
    random_desired(); encode();
    d0 = done_cnt;
    load(2, 200, -1);
    @(negedge clk); chk("abort200_busy", 32'(cfg_busy), 32'd0);
    tick();
    load(0, TW - 1, -1);
    @(negedge clk); chk("abort399_busy", 32'(cfg_busy), 32'd0);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    tick(); fpga_in = 4'hF; @(negedge clk); chk("abort_old_and", 32'(fpga_out[0]), 32'd1);
    tick();

    // Valid toggling every other cycle
    random_desired(); encode();
    d0 = done_cnt; r0 = ready_cyc;
    load(1, -1, -1);
    chk("toggle_load_cycles", 32'(ready_cyc - r0), 32'd799);
    chk("toggle_done_once", 32'(done_cnt - d0), 32'd1);
    repeat (3) begin fpga_in = 4'($urandom); tick(); end

    // Reset after 100 bits, then a fresh full load
    random_desired(); encode();
    load(0, -1, 100);
    @(negedge clk);
    chk("rst_mid_out", 32'(fpga_out), 32'h0);
    chk("rst_mid_busy", 32'(cfg_busy), 32'd0);
    tick();
    d0 = done_cnt;
    load(2, -1, -1);
    chk("after_rst_done", 32'(done_cnt - d0), 32'd1);

    // Random loads with occasional aborts
    for (int k = 0; k < 4; k++) begin
      random_desired(); encode();
      load(2, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TW - 1)) : -1, -1);
      repeat (4) begin fpga_in = 4'($urandom); tick(); end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/cfg_lut_array.md
Name: cfg_lut_array

Overview:
Parametrised, runtime-programmable array of K-input LUTs. It is the configurable successor to the fixed-function LUT design.
- Each LUT has a truth table, per-input routing selects and an optional output flip-flop.
- All three are loaded through a serial configuration port with a valid/ready handshake, then committed atomically.
- Sits between the primary fpga_in/fpga_out pins and the configuration controller.

Parameters:
NUM_LUTS, 16, number of LUT cells (one output each)
LUT_K, 4, inputs per LUT
NUM_IN, 4, width of the primary input bus
SEL_W, $clog2(NUM_IN), width of one input-select field (derived, not overridden)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
fpga_in  in  NUM_IN  primary inputs
fpga_out  out  NUM_LUTS  LUT outputs; bit i from LUT i
cfg_start  in  1  begin a configuration load (accepted only in IDLE)
cfg_abort  in  1  discard an in-progress load
cfg_valid  in  1  cfg_din is valid this cycle
cfg_din  in  1  serial configuration bit
cfg_ready  out  1  array accepts a cfg bit this cycle
cfg_done  out  1  one-cycle pulse when the new configuration becomes active
cfg_busy  out  1  high in LOAD and COMMIT

Behaviour:
Clocking and reset:
- Single clock domain. Reset is synchronous and active-low: rst_n is sampled on the rising edge of clk.
- Reset state: FSM IDLE; bit counter 0; shadow and active config all zero; all output FFs 0.
- After reset: fpga_out=0 (all-zero truth tables), cfg_ready=0, cfg_done=0, cfg_busy=0.

Config word per LUT (LUT_CFG_W = 2^LUT_K + LUT_K*SEL_W + 1; 25 bits at defaults):
- [2^K-1:0] truth table. Bit n is the output when {in[K-1],...,in[0]} = n.
- Next LUT_K*SEL_W bits: select fields. Field j is at offset 2^K + j*SEL_W, and LUT input j = fpga_in[sel_j].
- A select value >= NUM_IN drives that LUT input to 0.
- Top bit: reg_en.

Config stream:
- Total length TOTAL_W = NUM_LUTS*LUT_CFG_W (400 at defaults).
- Stream is LSB-first, LUT 0 first.
- The shadow register shifts right, with the new bit entering the MSB. After TOTAL_W accepted bits, stream bit 0 sits at shadow bit 0.

FSM:
- IDLE: cfg_start -> LOAD, count cleared. cfg_ready is 0 in IDLE.
- LOAD: cfg_ready=1. A bit is accepted when cfg_valid && cfg_ready; each accepted bit shifts the shadow register and increments count.
- LOAD, on accepting bit TOTAL_W-1 -> COMMIT.
- LOAD, on cfg_abort -> IDLE. Shadow contents are discarded and the active config is unchanged.
- COMMIT (one cycle): active <= shadow, cfg_done=1, cfg_ready=0, then -> IDLE.

Boundary and priority rules:
- cfg_abort on the same cycle as the final bit: abort wins, no commit.
- cfg_start outside IDLE is ignored.
- cfg_valid outside LOAD is ignored.
- Reset mid-load returns to the reset state; the active config is cleared.

Datapath:
- The datapath always evaluates the active config. During LOAD, outputs keep following the old config.
- reg_en=0: fpga_out[i] is combinational from fpga_in (zero-cycle latency).
- reg_en=1: fpga_out[i] is the LUT result registered every cycle (one-cycle latency).
- A new config affects combinational LUTs in the cycle after COMMIT. Registered LUTs show the new function one cycle later.

Decomposition:
- Package cfg_lut_array_pkg holds:
  - LUT_CFG_W, TOTAL_W and the field-offset functions;
  - the FSM state enum {IDLE, LOAD, COMMIT};
  - the counter width, $clog2(TOTAL_W+1).
- Sub-module cfg_lut_cell, instantiated NUM_LUTS times. It contains the K select muxes, the 2^K truth-table lookup, the output FF and the reg_en bypass mux.
- The top level holds the FSM, counter, shadow register and active register.

Test Plan:
- Reset with fpga_in=4'hF -> fpga_out=16'h0000, cfg_ready=0, cfg_busy=0.
- Load 400 bits. LUT0: table 16'h8000, selects {3,2,1,0} (select bits 8'hE4), reg_en=0. All other LUTs zero. Then:
  - cfg_done pulses exactly once, one cycle after the last bit;
  - fpga_in=4'hF -> fpga_out[0]=1 in the same cycle;
  - fpga_in=4'hE -> fpga_out[0]=0.
- Load LUT1: table 16'h6996 (XOR4), selects {0,1,2,3}, reg_en=1. Step fpga_in 4'h1 -> 4'h3 -> fpga_out[1] is 1 then 0, each one cycle after the input change.
- Load with cfg_valid toggling every other cycle -> exactly 400 bits accepted, 799 LOAD cycles, one cfg_done, correct config active.
- cfg_abort after 200 bits, and separately abort coincident with bit 399 -> no cfg_done, previous config still drives fpga_out, FSM back in IDLE.
- rst_n=0 for one cycle after 100 bits -> fpga_out=0, cfg_busy=0, count=0; a fresh cfg_start followed by a full load succeeds.
